// File: rtl/pwm_spi_pkg.sv
// Shared constants, FSM states and frame builder
// for the PWM driver SPI master.
package pwm_spi_pkg;

  localparam int NUM_CHANNELS   = 7;
  localparam int ADDR_W         = 3;
  localparam int LEVEL_W        = 8;
  localparam int FRAME_W        = 16;
  localparam int WRITE_FLAG_BIT = 7;
  localparam int CMD_W          = FRAME_W - LEVEL_W;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SCLK_HI,
    SCLK_LO,
    CS_GAP
  } state_e;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic               wr,
    input logic [ADDR_W-1:0]  addr,
    input logic [LEVEL_W-1:0] data
  );
    logic [CMD_W-1:0] cmd;
    cmd                 = '0;
    cmd[WRITE_FLAG_BIT] = wr;
    cmd[ADDR_W-1:0]     = addr;
    return {cmd, (wr ? data : LEVEL_W'(0))};
  endfunction

endpackage

// File: rtl/pwm_spi_if.sv
// Command/response bundle between a requester
// and the PWM SPI master.
interface pwm_spi_if;
  import pwm_spi_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [LEVEL_W-1:0] cmd_wdata;
  logic               rsp_valid;
  logic [LEVEL_W-1:0] rsp_rdata;
  logic               rsp_err;
  logic               busy;

  modport master (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid,
    input  rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid,
    output rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/spi_half_period_timer.sv
// Down-counter reloaded on each FSM state entry;
// phase_done marks the last cycle of a phase.
module spi_half_period_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic phase_done_o
);

  localparam int CW =
    (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(HALF_PERIOD - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign phase_done_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_spi_master.sv
// Turns single-beat channel commands into 16-bit
// SPI frames for the PWM driver.
module pwm_spi_master
  import pwm_spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic      clk,
  input  logic      reset,
  pwm_spi_if.slave  bus,
  output logic      spi_cs_n,
  output logic      spi_sclk,
  output logic      spi_mosi,
  input  logic      spi_miso
);

  state_e state_q, state_d;

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [LEVEL_W-1:0] rx_q, rx_d;
  logic [LEVEL_W-1:0] rdata_q, rdata_d;
  logic [3:0]         bit_q, bit_d;
  logic               wr_q, wr_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic               load, done, accept;
  logic [FRAME_W-1:0] frame;

  spi_half_period_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .phase_done_o (done)
  );

  assign bus.cmd_ready = (state_q == IDLE);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign frame  = build_frame(bus.cmd_write,
                              bus.cmd_addr,
                              bus.cmd_wdata);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    bit_d    = bit_q;
    wr_d     = wr_q;
    mosi_d   = mosi_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_addr == ADDR_W'(NUM_CHANNELS)) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end else begin
            wr_d    = bus.cmd_write;
            mosi_d  = frame[FRAME_W-1];
            shreg_d = frame << 1;
            bit_d   = '0;
            rx_d    = '0;
            state_d = CS_SETUP;
          end
        end
      end
      CS_SETUP: begin
        if (done) state_d = SCLK_HI;
      end
      SCLK_HI: begin
        if (done) begin
          // second byte of a read carries data, LSB first
          if (!wr_q && bit_q[3])
            rx_d = {spi_miso, rx_q[LEVEL_W-1:1]};
          mosi_d  = shreg_q[FRAME_W-1];
          shreg_d = shreg_q << 1;
          state_d = SCLK_LO;
        end
      end
      SCLK_LO: begin
        if (done) begin
          if (bit_q == 4'(FRAME_W - 1)) begin
            state_d = CS_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = SCLK_HI;
          end
        end
      end
      CS_GAP: begin
        if (done) begin
          rvalid_d = 1'b1;
          err_d    = 1'b0;
          rdata_d  = wr_q ? '0 : rx_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load   = (state_d != state_q);
  assign cs_n_d = (state_d == IDLE) ||
                  (state_d == CS_GAP);
  assign sclk_d = (state_d == SCLK_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      bit_q    <= '0;
      wr_q     <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      bit_q    <= bit_d;
      wr_q     <= wr_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);
  assign spi_cs_n      = cs_n_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;

endmodule
